// File: rtl/vemicry_dmem_responder.sv
// VeMICry data-memory responder: accepts one load/store at a time, holds the
// core with mem_stall for a configurable wait-state latency, and returns
// zero-extended load data with a one-cycle mem_done/mem_err completion pulse.
module vemicry_dmem_responder #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        typ,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_add,
  input  logic [31:0]       data_in_mem,
  output logic [31:0]       memdataout,
  output logic              mem_stall,
  output logic              mem_done,
  output logic              mem_err
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int KEEP_W  = IDX_W + 2;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [KEEP_W-1:0] add_q;
  logic [1:0]        typ_q;
  logic [31:0]       din_q;
  logic [31:0]       mem_q [DEPTH];

  logic              is_idle;
  logic              req;
  logic              bad;
  logic [KEEP_W-1:0] add_s;
  logic [1:0]        typ_s;
  logic [31:0]       din_s;
  logic [IDX_W-1:0]  idx_s;
  logic [1:0]        lane_s;
  logic [31:0]       rdata_d;
  logic [31:0]       wdata_d;
  logic [3:0]        be_d;
  logic              wr_fire;

  // Address bits above the wrapped word index are intentionally ignored.
  if (ADDR_W > KEEP_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^data_add[ADDR_W-1:KEEP_W];
  end

  // Rejected requests: conflicting direction, reserved size, misalignment.
  function automatic logic req_error(input logic rd, input logic wr,
                                     input logic [1:0] t, input logic [1:0] lane);
    req_error = (rd & wr) | (t == 2'b11) | ((t == 2'b01) & lane[0]) |
                ((t == 2'b00) & (lane != 2'b00));
  endfunction

  // Little-endian lane extraction, zero-extended.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0] t,
                                               input logic [1:0] lane);
    case (t)
      2'b01:   load_extract = lane[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      2'b10: begin
        case (lane)
          2'b00:   load_extract = {24'h0, w[7:0]};
          2'b01:   load_extract = {24'h0, w[15:8]};
          2'b10:   load_extract = {24'h0, w[23:16]};
          default: load_extract = {24'h0, w[31:24]};
        endcase
      end
      default: load_extract = w;
    endcase
  endfunction

  // Byte enables for a store of size t at lane offset.
  function automatic logic [3:0] store_enables(input logic [1:0] t, input logic [1:0] lane);
    case (t)
      2'b00:   store_enables = 4'b1111;
      2'b01:   store_enables = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   store_enables = 4'b0001 << lane;
      default: store_enables = 4'b0000;
    endcase
  endfunction

  // Right-justified store data replicated onto every lane; enables pick one.
  function automatic logic [31:0] store_data(input logic [1:0] t, input logic [31:0] d);
    case (t)
      2'b01:   store_data = {2{d[15:0]}};
      2'b10:   store_data = {4{d[7:0]}};
      default: store_data = d;
    endcase
  endfunction

  assign is_idle   = (state_q == IDLE);
  assign req       = data_read | data_write;
  assign bad       = req_error(data_read, data_write, typ, data_add[1:0]);
  assign mem_stall = (is_idle & req) | (state_q == RD_WAIT) | (state_q == WR_WAIT);

  // Access operands: live inputs in IDLE (single-cycle latency), latched copy while waiting.
  always_comb begin
    add_s   = is_idle ? data_add[KEEP_W-1:0] : add_q;
    typ_s   = is_idle ? typ : typ_q;
    din_s   = is_idle ? data_in_mem : din_q;
    idx_s   = add_s[KEEP_W-1:2];
    lane_s  = add_s[1:0];
    rdata_d = load_extract(mem_q[idx_s], typ_s, lane_s);
    wdata_d = store_data(typ_s, din_s);
    be_d    = store_enables(typ_s, lane_s);
  end

  assign wr_fire = ~reset &
                   ((is_idle & data_write & ~bad & (WR_LAT == 1)) |
                    ((state_q == WR_WAIT) & (cnt_q == CNT_W'(1))));

  // Storage commit with byte enables; reset leaves contents untouched.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[idx_s][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  // Request FSM with registered load data and completion pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      memdataout <= '0;
      mem_done   <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            add_q <= data_add[KEEP_W-1:0];
            typ_q <= typ;
            din_q <= data_in_mem;
            if (bad) begin
              state_q  <= DONE;
              mem_done <= 1'b1;
              mem_err  <= 1'b1;
            end else if (data_read) begin
              if (RD_LAT == 1) begin
                memdataout <= rdata_d;
                mem_done   <= 1'b1;
                state_q    <= DONE;
              end else begin
                cnt_q   <= CNT_W'(RD_LAT - 1);
                state_q <= RD_WAIT;
              end
            end else begin
              if (WR_LAT == 1) begin
                mem_done <= 1'b1;
                state_q  <= DONE;
              end else begin
                cnt_q   <= CNT_W'(WR_LAT - 1);
                state_q <= WR_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            memdataout <= rdata_d;
            mem_done   <= 1'b1;
            state_q    <= DONE;
          end
        end
        WR_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            mem_done <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vemicry_dmem_responder.sv
// Directed bench: d1 uses RD_LAT=2/WR_LAT=1, d2 uses RD_LAT=3/WR_LAT=2.
module tb_vemicry_dmem_responder;

  logic        clk;
  logic        rst1, rst2;
  logic        rd1, wr1, rd2, wr2;
  logic [1:0]  typ_s;
  logic [15:0] add_s;
  logic [31:0] din_s;
  logic [31:0] q1, q2;
  logic        st1, st2, dn1, dn2, er1, er2;

  int total = 0;
  int bad   = 0;

  vemicry_dmem_responder #(.ADDR_W(16), .DEPTH(1024), .RD_LAT(2), .WR_LAT(1)) d1 (
    .clock(clk), .reset(rst1), .typ(typ_s), .data_read(rd1), .data_write(wr1),
    .data_add(add_s), .data_in_mem(din_s), .memdataout(q1), .mem_stall(st1),
    .mem_done(dn1), .mem_err(er1));

  vemicry_dmem_responder #(.ADDR_W(16), .DEPTH(1024), .RD_LAT(3), .WR_LAT(2)) d2 (
    .clock(clk), .reset(rst2), .typ(typ_s), .data_read(rd2), .data_write(wr2),
    .data_add(add_s), .data_in_mem(din_s), .memdataout(q2), .mem_stall(st2),
    .mem_done(dn2), .mem_err(er2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int w, input logic rd, input logic wr);
    if (w == 2) begin rd2 = rd; wr2 = wr; end
    else begin rd1 = rd; wr1 = wr; end
  endtask

  function automatic logic [31:0] o_q(input int w);
    return (w == 2) ? q2 : q1;
  endfunction
  function automatic logic o_st(input int w);
    return (w == 2) ? st2 : st1;
  endfunction
  function automatic logic o_dn(input int w);
    return (w == 2) ? dn2 : dn1;
  endfunction
  function automatic logic o_er(input int w);
    return (w == 2) ? er2 : er1;
  endfunction

  // One request held for cycle T only; lat = cycles to completion.
  task automatic access(input int w, input logic rd, input logic wr, input logic [1:0] t,
                        input logic [15:0] a, input logic [31:0] d, input int lat,
                        input logic exp_err, input logic [31:0] exp_q, input string tag);
    step();
    set_req(w, rd, wr);
    typ_s = t; add_s = a; din_s = d;
    sample();
    chk({tag, ".stallT"}, o_st(w), 1);
    step();
    set_req(w, 0, 0);
    for (int c = 1; c < lat; c++) begin
      sample();
      chk({tag, ".stallW"}, o_st(w), 1);
      chk({tag, ".doneW"}, o_dn(w), 0);
      step();
    end
    sample();
    chk({tag, ".done"}, o_dn(w), 1);
    chk({tag, ".err"}, o_er(w), exp_err);
    chk({tag, ".stallD"}, o_st(w), 0);
    chk({tag, ".data"}, o_q(w), exp_q);
  endtask

  initial begin
    rst1 = 1; rst2 = 1; rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0;
    typ_s = 0; add_s = 0; din_s = 0;
    step(); step();
    rst1 = 0; rst2 = 0;
    sample();
    chk("rst.q1", q1, 0);     chk("rst.dn1", dn1, 0);
    chk("rst.er1", er1, 0);   chk("rst.st1", st1, 0);
    chk("rst.q2", q2, 0);     chk("rst.dn2", dn2, 0);

    // Word write then read
    access(1, 0, 1, 2'b00, 16'h0010, 32'hDEADBEEF, 1, 0, 32'h0, "wr10");
    access(1, 1, 0, 2'b00, 16'h0010, 32'h0, 2, 0, 32'hDEADBEEF, "rd10");

    // Byte merge
    access(1, 0, 1, 2'b00, 16'h0020, 32'h00000000, 1, 0, 32'hDEADBEEF, "wr20");
    access(1, 0, 1, 2'b10, 16'h0021, 32'h123456AA, 1, 0, 32'hDEADBEEF, "wb21");
    access(1, 0, 1, 2'b10, 16'h0023, 32'h00000055, 1, 0, 32'hDEADBEEF, "wb23");
    access(1, 1, 0, 2'b00, 16'h0020, 32'h0, 2, 0, 32'h5500AA00, "rd20");
    access(1, 0, 1, 2'b00, 16'h0000, 32'hCAFEF00D, 1, 0, 32'h5500AA00, "wr00");

    // Sub-word reads
    access(1, 1, 0, 2'b01, 16'h0022, 32'h0, 2, 0, 32'h00005500, "rh22");
    access(1, 1, 0, 2'b10, 16'h0021, 32'h0, 2, 0, 32'h000000AA, "rb21");

    // Errors: memdataout must stay 0xAA
    access(1, 1, 0, 2'b01, 16'h0003, 32'h0, 1, 1, 32'h000000AA, "e_half");
    access(1, 0, 1, 2'b00, 16'h0002, 32'hFFFFFFFF, 1, 1, 32'h000000AA, "e_word");
    access(1, 1, 1, 2'b00, 16'h0000, 32'h00000000, 1, 1, 32'h000000AA, "e_rdwr");
    access(1, 0, 1, 2'b11, 16'h0000, 32'h00000000, 1, 1, 32'h000000AA, "e_typ");
    access(1, 1, 0, 2'b00, 16'h0000, 32'h0, 2, 0, 32'hCAFEF00D, "rd00");

    // Wrap
    access(1, 0, 1, 2'b00, 16'h1004, 32'h12345678, 1, 0, 32'hCAFEF00D, "wr1004");
    access(1, 1, 0, 2'b00, 16'h0004, 32'h0, 2, 0, 32'h12345678, "rd0004");

    // Request held through DONE: not re-accepted there, accepted in next IDLE
    step(); rd1 = 1; typ_s = 2'b00; add_s = 16'h0004;
    sample(); chk("hold.stT", st1, 1);
    step(); sample(); chk("hold.stT1", st1, 1); chk("hold.dnT1", dn1, 0);
    step(); sample(); chk("hold.dnT2", dn1, 1); chk("hold.stT2", st1, 0);
    step(); sample(); chk("hold.stT3", st1, 1); chk("hold.dnT3", dn1, 0);
    step(); sample(); chk("hold.stT4", st1, 1); chk("hold.dnT4", dn1, 0);
    step(); rd1 = 0;
    sample(); chk("hold.dnT5", dn1, 1); chk("hold.qT5", q1, 32'h12345678);

    // d2 latencies
    access(2, 0, 1, 2'b00, 16'h0040, 32'h11112222, 2, 0, 32'h0, "d2wr");
    access(2, 1, 0, 2'b00, 16'h0040, 32'h0, 3, 0, 32'h11112222, "d2rd");

    // Read aborted by reset in T+1
    step(); rd2 = 1; typ_s = 2'b00; add_s = 16'h0040;
    sample(); chk("ard.stT", st2, 1);
    step(); rd2 = 0; rst2 = 1;
    sample(); chk("ard.dnT1", dn2, 0);
    step(); rst2 = 0;
    sample(); chk("ard.q", q2, 0); chk("ard.dnT2", dn2, 0); chk("ard.st", st2, 0);
    for (int c = 0; c < 3; c++) begin
      step(); sample(); chk("ard.nodone", dn2, 0);
    end

    // Write aborted by reset in T; new read accepted right after reset drops
    step(); wr2 = 1; typ_s = 2'b00; add_s = 16'h0040; din_s = 32'hDEAD0000; rst2 = 1;
    sample();
    step(); wr2 = 0; rst2 = 0; rd2 = 1;
    sample(); chk("awr.stT1", st2, 1); chk("awr.dnT1", dn2, 0);
    step(); rd2 = 0;
    sample(); chk("awr.stT2", st2, 1); chk("awr.dnT2", dn2, 0);
    step(); sample(); chk("awr.stT3", st2, 1); chk("awr.dnT3", dn2, 0);
    step(); sample();
    chk("awr.dnT4", dn2, 1); chk("awr.erT4", er2, 0);
    chk("awr.stT4", st2, 0); chk("awr.q", q2, 32'h11112222);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
